// File: rtl/load_insn_dispatch_if.sv
// Load-queue read port and load-engine issue handshake seen by the load dispatcher.
interface load_insn_dispatch_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  q_empty_i;
    logic                  q_rd_en_o;
    logic [DATA_WIDTH-1:0] q_rd_data_i;
    logic                  insn_valid_o;
    logic                  insn_ready_i;
    logic [DATA_WIDTH-1:0] insn_data_o;
    logic                  insn_done_i;

    modport master (
        input  q_empty_i, q_rd_data_i, insn_ready_i, insn_done_i,
        output q_rd_en_o, insn_valid_o, insn_data_o
    );
    modport slave (
        output q_empty_i, q_rd_data_i, insn_ready_i, insn_done_i,
        input  q_rd_en_o, insn_valid_o, insn_data_o
    );
endinterface

// File: rtl/load_insn_dispatch.sv
// Load-stage dispatcher: pops VTA insns, resolves g2l tokens, issues one load at a time, emits l2g.
// Optional issue/stall counters are built when LOAD_DISPATCH_STATS_EN is defined.
module load_insn_dispatch #(
    parameter int DATA_WIDTH = 128,
    parameter int TOKEN_W    = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    load_insn_dispatch_if.master bus,
    input  logic                 g2l_token_i,
    output logic                 l2g_token_o,
    output logic [TOKEN_W-1:0]   token_cnt_o,
    output logic                 busy_o,
    output logic                 err_o
`ifdef LOAD_DISPATCH_STATS_EN
    ,
    output logic [31:0]          issued_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_CAPT, S_DEP, S_ISSUE, S_EXEC, S_PUSH} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] insn_q;
    logic [TOKEN_W-1:0]    cnt_q;
    logic                  err_q;
    logic                  is_load, pop_next, push_next;
    logic                  tok_avail, tok_wait, tok_dec, tok_sat;

    assign is_load   = (insn_q[2:0] == 3'd0);
    assign pop_next  = insn_q[4];
    assign push_next = insn_q[6];

    // A token arriving this cycle can satisfy the dependency immediately.
    assign tok_avail = (cnt_q != '0) || g2l_token_i;
    assign tok_wait  = (state == S_DEP) && pop_next && !tok_avail;
    assign tok_dec   = (state == S_DEP) && pop_next && tok_avail;
    assign tok_sat   = g2l_token_i && !tok_dec && (cnt_q == '1);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!bus.q_empty_i) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_DEP;
            S_DEP:   if (!tok_wait) state_nxt = is_load ? S_ISSUE : S_PUSH;
            S_ISSUE: if (bus.insn_ready_i) state_nxt = S_EXEC;
            S_EXEC:  if (bus.insn_done_i) state_nxt = S_PUSH;
            S_PUSH:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read strobe is gated by reset so a held reset never drains the queue.
    always_comb begin
        bus.q_rd_en_o    = 1'b0;
        bus.insn_valid_o = 1'b0;
        l2g_token_o      = 1'b0;
        busy_o           = (state != S_IDLE);
        case (state)
            S_IDLE:  bus.q_rd_en_o = !bus.q_empty_i && ap_rst_n;
            S_ISSUE: bus.insn_valid_o = 1'b1;
            S_PUSH:  l2g_token_o = push_next;
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)            insn_q <= '0;
        else if (state == S_CAPT) insn_q <= bus.q_rd_data_i;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (tok_sat) begin
            err_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + TOKEN_W'(g2l_token_i) - TOKEN_W'(tok_dec);
        end
    end

    assign bus.insn_data_o = insn_q;
    assign token_cnt_o     = cnt_q;
    assign err_o           = err_q;

`ifdef LOAD_DISPATCH_STATS_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            issued_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (bus.insn_valid_o && bus.insn_ready_i) issued_cnt_o <= issued_cnt_o + 32'd1;
            if (tok_wait)                             stall_cnt_o  <= stall_cnt_o + 32'd1;
        end
    end
`endif
endmodule
